// File: rtl/execute_stage_if.sv
// Issue-side and memory-side handshake bundle for the Y86-64 execute stage.
// slave is the stage itself; master is whoever drives decode fields and drains results.
interface execute_stage_if;
    logic               in_valid;
    logic               in_ready;
    logic        [3:0]  icode;
    logic        [3:0]  ifun;
    logic signed [63:0] valA;
    logic signed [63:0] valB;
    logic signed [63:0] valC;
    logic               out_valid;
    logic               out_ready;
    logic        [3:0]  out_icode;
    logic signed [63:0] valE;
    logic               cnd;
    logic        [2:0]  cc;
    logic               halted;
    logic               err;

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, out_ready,
        output in_ready, out_valid, out_icode, valE, cnd, cc, halted, err
    );

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, out_ready,
        input  in_ready, out_valid, out_icode, valE, cnd, cc, halted, err
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand/function select, 64-bit ALU, condition codes,
// branch/cmov condition and a one-entry registered result buffer.
module alu (
    input  logic        [1:0]  i_fun,
    input  logic signed [63:0] i_a,
    input  logic signed [63:0] i_b,
    output logic signed [63:0] o_res,
    output logic               o_of
);
    always_comb begin
        o_res = '0;
        o_of  = 1'b0;
        case (i_fun)
            2'b00: begin
                o_res = i_a + i_b;
                o_of  = (i_a[63] == i_b[63]) && (o_res[63] != i_a[63]);
            end
            2'b01: begin
                o_res = i_a - i_b;
                o_of  = (i_a[63] != i_b[63]) && (o_res[63] != i_a[63]);
            end
            2'b10:   o_res = i_a & i_b;
            default: o_res = i_a ^ i_b;
        endcase
    end
endmodule

module execute_stage (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  bus
);
    localparam int DATA_W = 64;

    localparam logic [3:0] IC_HALT  = 4'h0;
    localparam logic [3:0] IC_CMOV  = 4'h2;
    localparam logic [3:0] IC_IRMOV = 4'h3;
    localparam logic [3:0] IC_RMMOV = 4'h4;
    localparam logic [3:0] IC_MRMOV = 4'h5;
    localparam logic [3:0] IC_OPQ   = 4'h6;
    localparam logic [3:0] IC_JXX   = 4'h7;
    localparam logic [3:0] IC_CALL  = 4'h8;
    localparam logic [3:0] IC_RET   = 4'h9;
    localparam logic [3:0] IC_PUSH  = 4'hA;
    localparam logic [3:0] IC_POP   = 4'hB;

    localparam logic [1:0] FN_ADD = 2'b00;

    // cc is packed {ZF,SF,OF}; X = SF^OF drives the signed comparisons
    function automatic logic f_cond(input logic [3:0] ifun, input logic [2:0] cc);
        logic x;
        x = cc[1] ^ cc[0];
        case (ifun)
            4'd0:    f_cond = 1'b1;
            4'd1:    f_cond = x | cc[2];
            4'd2:    f_cond = x;
            4'd3:    f_cond = cc[2];
            4'd4:    f_cond = ~cc[2];
            4'd5:    f_cond = ~x;
            4'd6:    f_cond = ~x & ~cc[2];
            default: f_cond = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] f_next_cc(input logic signed [DATA_W-1:0] res,
                                             input logic of, input logic [1:0] fun);
        f_next_cc = {(res == '0), res[DATA_W-1], of & ~fun[1]};
    endfunction

    logic signed [DATA_W-1:0] w_aside;
    logic signed [DATA_W-1:0] w_bside;
    logic        [1:0]        w_fun;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_of;
    logic                     w_invalid;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_is_cond;

    logic                     r_vld_p1;
    logic        [3:0]        r_icode_p1;
    logic signed [DATA_W-1:0] r_vale_p1;
    logic                     r_cnd_p1;
    logic        [2:0]        r_cc;
    logic                     r_halted;
    logic                     r_err;

    always_comb begin
        w_aside = '0;
        w_bside = '0;
        w_fun   = FN_ADD;
        case (bus.icode)
            IC_CMOV:  w_aside = bus.valA;
            IC_IRMOV: w_aside = bus.valC;
            IC_RMMOV, IC_MRMOV: begin
                w_aside = bus.valC;
                w_bside = bus.valB;
            end
            IC_OPQ: begin
                w_aside = bus.valA;
                w_bside = bus.valB;
                w_fun   = bus.ifun[1:0];
            end
            IC_CALL, IC_PUSH: begin
                w_aside = -64'sd8;
                w_bside = bus.valB;
            end
            IC_RET, IC_POP: begin
                w_aside = 64'sd8;
                w_bside = bus.valB;
            end
            default: ;
        endcase
    end

    assign w_is_cond  = (bus.icode == IC_JXX) || (bus.icode == IC_CMOV);
    assign w_invalid  = (bus.icode > IC_POP)
                      || ((bus.icode == IC_OPQ) && (bus.ifun > 4'd3))
                      || (w_is_cond && (bus.ifun > 4'd6));
    assign w_in_ready = ~r_halted & (~r_vld_p1 | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    // ALU port A carries the B-side operand so sub yields valB - valA
    alu u_alu (
        .i_fun (w_fun),
        .i_a   (w_bside),
        .i_b   (w_aside),
        .o_res (w_res),
        .o_of  (w_of)
    );

    // ---- stage p1: registered result buffer and architectural state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_icode_p1 <= '0;
            r_vale_p1  <= '0;
            r_cnd_p1   <= 1'b0;
            r_cc       <= 3'b100;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1   <= 1'b1;
            r_icode_p1 <= bus.icode;
            r_vale_p1  <= w_invalid ? '0 : w_res;
            r_cnd_p1   <= ~w_invalid & w_is_cond & f_cond(bus.ifun, r_cc);
            if ((bus.icode == IC_OPQ) && !w_invalid)
                r_cc <= f_next_cc(w_res, w_of, w_fun);
            if (w_invalid) begin
                r_halted <= 1'b1;
                r_err    <= 1'b1;
            end else if (bus.icode == IC_HALT) begin
                r_halted <= 1'b1;
            end
        end else if (r_vld_p1 && bus.out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p1;
    assign bus.out_icode = r_icode_p1;
    assign bus.valE      = r_vale_p1;
    assign bus.cnd       = r_cnd_p1;
    assign bus.cc        = r_cc;
    assign bus.halted    = r_halted;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: an independent Y86 model predicts each
// accepted instruction's result, which is compared when the stage retires it.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_stage_if bus ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] ve;
        logic        cn;
        logic [2:0]  cc;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] m_cc;
    int         n_vec;
    int         n_bad;
    bit         acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] c, input logic [2:0] cc_in);
        exp_t        e;
        logic [64:0] wide;
        logic        x;
        logic        bad;
        e.ic = ic;
        e.ve = '0;
        e.cn = 1'b0;
        e.cc = cc_in;
        bad  = (ic > 4'hB) || (ic == 4'h6 && fn > 4'd3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6);
        x    = cc_in[1] ^ cc_in[0];
        if (!bad) begin
            case (ic)
                4'h2:       e.ve = a;
                4'h3:       e.ve = c;
                4'h4, 4'h5: e.ve = b + c;
                4'h8, 4'hA: e.ve = b - 64'd8;
                4'h9, 4'hB: e.ve = b + 64'd8;
                4'h6: begin
                    wide = '0;
                    case (fn[1:0])
                        2'd0: wide = {b[63], b} + {a[63], a};
                        2'd1: wide = {b[63], b} - {a[63], a};
                        2'd2: wide = {1'b0, b & a};
                        default: wide = {1'b0, b ^ a};
                    endcase
                    e.ve = wide[63:0];
                    e.cc = {(e.ve == 64'd0), e.ve[63], (fn[1] == 1'b0) && (wide[64] != wide[63])};
                end
                default: ;
            endcase
            if (ic == 4'h2 || ic == 4'h7) begin
                case (fn)
                    4'd0: e.cn = 1'b1;
                    4'd1: e.cn = x | cc_in[2];
                    4'd2: e.cn = x;
                    4'd3: e.cn = cc_in[2];
                    4'd4: e.cn = ~cc_in[2];
                    4'd5: e.cn = ~x;
                    default: e.cn = ~x & ~cc_in[2];
                endcase
            end
        end
        return e;
    endfunction

    task automatic sample();
        exp_t e;
        acc = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_icode", bus.out_icode, e.ic);
                chk("valE", bus.valE, e.ve);
                chk("cnd", bus.cnd, e.cn);
                chk("cc", bus.cc, e.cc);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e    = model(bus.icode, bus.ifun, bus.valA, bus.valB, bus.valC, m_cc);
            m_cc = e.cc;
            sb.push_back(e);
            acc = 1'b1;
        end
    endtask

    task automatic step();
        #1 sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bus.icode    = ic;
        bus.ifun     = fn;
        bus.valA     = a;
        bus.valB     = b;
        bus.valC     = c;
        bus.in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bit done;
        done = 1'b0;
        drive(ic, fn, a, b, c);
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = acc;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        sb.delete();
        m_cc = 3'b100;
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [63:0] BIG = 64'h7FFF_FFFF_FFFF_FFFF;

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_cc  = 3'b100;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.icode = '0;
        bus.ifun  = '0;
        bus.valA  = '0;
        bus.valB  = '0;
        bus.valC  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 64'd0);
        chk("rst_valE", bus.valE, 64'd0);
        chk("rst_cc", bus.cc, 64'd4);
        chk("rst_halted", bus.halted, 64'd0);
        chk("rst_err", bus.err, 64'd0);
        chk("rst_in_ready", bus.in_ready, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // flags, branch condition, overflow, stack-pointer arithmetic
        send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        chk("subq_valE", bus.valE, 64'd0);
        chk("subq_cc", bus.cc, 64'd4);
        send(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        chk("jle_cnd", bus.cnd, 64'd1);
        send(4'h6, 4'h0, BIG, BIG, 64'd0);
        chk("addq_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("addq_cc", bus.cc, 64'd3);
        send(4'h6, 4'h2, BIG, BIG, 64'd0);
        chk("andq_cc", bus.cc, 64'd0);
        send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
        chk("pushq_valE", bus.valE, 64'hF8);
        send(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
        chk("popq_valE", bus.valE, 64'h100);
        send(4'h2, 4'h4, 64'h123, 64'd0, 64'd0);
        send(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD);
        send(4'h4, 4'h0, 64'd0, 64'h10, 64'h8);
        send(4'h8, 4'h0, 64'd0, 64'h200, 64'd0);
        send(4'h6, 4'h3, 64'hF0F0, 64'hFF00, 64'd0);
        send(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
        send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        send(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
        step();

        // backpressure: result held, second instruction waits then enters on release
        bus.out_ready = 1'b0;
        send(4'h6, 4'h1, 64'd3, 64'd10, 64'd0);
        #1;
        chk("bp_in_ready", bus.in_ready, 64'd0);
        drive(4'h6, 4'h1, 64'd1, 64'd1, 64'd0);
        repeat (3) step();
        chk("bp_hold_valE", bus.valE, 64'd7);
        chk("bp_hold_cc", bus.cc, 64'd0);
        chk("bp_hold_valid", bus.out_valid, 64'd1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_accept", acc, 64'd1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drain", sb.size(), 64'd0);

        // halt stays presented under backpressure, then async reset drops it
        bus.out_ready = 1'b0;
        send(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        chk("halt_halted", bus.halted, 64'd1);
        chk("halt_out_valid", bus.out_valid, 64'd1);
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        repeat (3) step();
        chk("halt_in_ready", bus.in_ready, 64'd0);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 64'd0);
        chk("arst_halted", bus.halted, 64'd0);
        chk("arst_cc", bus.cc, 64'd4);
        chk("arst_out_icode", bus.out_icode, 64'd0);
        bus.out_ready = 1'b1;
        do_reset();

        // halt retires normally and locks the input
        send(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        repeat (3) step();
        chk("halt_retired", bus.out_valid, 64'd0);
        chk("halt_locked", bus.in_ready, 64'd0);
        chk("halt_no_err", bus.err, 64'd0);
        do_reset();

        // invalid instructions
        send(4'h6, 4'h0, BIG, BIG, 64'd0);
        send(4'hC, 4'h0, 64'd5, 64'd6, 64'd7);
        chk("inv_err", bus.err, 64'd1);
        chk("inv_halted", bus.halted, 64'd1);
        chk("inv_valE", bus.valE, 64'd0);
        chk("inv_cc", bus.cc, 64'd3);
        step();
        do_reset();
        send(4'h6, 4'h5, 64'd1, 64'd1, 64'd0);
        chk("inv_opq_err", bus.err, 64'd1);
        step();
        do_reset();
        send(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
        chk("inv_jxx_err", bus.err, 64'd1);
        step();
        chk("final_drain", sb.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Sequential-processor execute stage that drives the 64-bit `alu` from the issue side. It accepts decoded Y86-64 instruction fields over a valid/ready handshake and selects the ALU operands and function. It maintains the condition-code register (ZF/SF/OF), evaluates branch/cmov conditions, and presents a registered result to the memory stage through a one-entry output buffer. The block instantiates `alu` internally, so ALU control and operands never appear on ports.

## Interface
- None: the block has no parameters. Word width is fixed at 64.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode-stage instruction valid.
- `in_ready` out 1: stage can accept an instruction this cycle.
- `icode` in 4: Y86 instruction code.
- `ifun` in 4: Y86 function code.
- `valA` in 64: register operand A.
- `valB` in 64: register operand B.
- `valC` in 64: immediate/displacement.
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: memory stage accepts the result.
- `out_icode` out 4: registered icode of the result.
- `valE` out 64: registered ALU result.
- `cnd` out 1: registered condition outcome.
- `cc` out 3: architectural {ZF,SF,OF}.
- `halted` out 1: sticky; set once halt or an invalid instruction is accepted.
- `err` out 1: sticky; set once an invalid icode is accepted.

## Operation
- ALU function codes: 00 = add, 01 = sub (A−B), 10 = and, 11 = xor. ALU port A is the "B-side" operand; ALU port B is the "A-side" operand.
- Operand selection, given as A-side / B-side:
  - rrmovq/cmovXX (2): valA / 0.
  - irmovq (3): valC / 0.
  - rmmovq (4), mrmovq (5): valC / valB.
  - OPq (6): valA / valB.
  - call (8), pushq (A): −8 / valB.
  - ret (9), popq (B): +8 / valB.
  - halt (0), nop (1), jXX (7): 0 / 0.
- ALU function: OPq uses ifun[1:0] when ifun ≤ 3. Every other icode uses add.
- OPq with ifun > 3 is invalid.
- icode > 0xB is invalid.
- Condition codes update only on acceptance of a valid OPq:
  - ZF = (result == 0).
  - SF = result[63].
  - OF = ALU overflow for add/sub; OF is forced to 0 for and/xor.
- `cnd`, for jXX and cmovXX only, is computed from the CC value held before the accepting edge. Let X = SF^OF.
  - ifun 0: 1.
  - ifun 1 (le): X|ZF.
  - ifun 2 (l): X.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~X.
  - ifun 6 (g): ~X&~ZF.
  - ifun > 6: invalid.
- `cnd` = 0 for all other icodes.
- On acceptance of halt: `halted` is set.
- On acceptance of an invalid instruction: `halted` and `err` are set, valE = 0, CC is unchanged.
- Reset values:
  - `out_valid`, `valE`, `cnd`, `out_icode`, `halted`, `err` = 0.
  - `cc` = {ZF=1, SF=0, OF=0}.

## Timing
- `in_ready` = ~halted & (~out_valid | out_ready). This is combinational from `out_ready`.
- Accept: `in_valid` & `in_ready` at a rising edge.
- Latency: 1 cycle. On the accepting edge, `valE`, `cnd`, `out_icode` and `cc` load and `out_valid` is set.
- Result retire: `out_valid` & `out_ready` at an edge. `out_valid` clears unless a new instruction is accepted on the same edge; a simultaneous accept replaces the result and keeps `out_valid` = 1.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0, all registered outputs hold. No CC update occurs because nothing is accepted.
- Input fields are sampled only on the accepting edge. Inputs while `in_ready` = 0 have no effect.
- After halt is accepted: the halt result is still presented and retires normally, and `in_ready` stays 0 until reset.
- Reset is asserted asynchronously at any time, including mid-handshake. All state goes to reset values immediately, and any pending result is dropped.

## Test plan
- OPq subq (6,1), valA=5, valB=5 -> next cycle valE=0, cc={1,0,0}. A following jle (7,1) yields cnd=1.
- OPq addq (6,0), valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, cc={0,1,1}. A following andq with the same operands yields cc={0,0,0}.
- pushq (A,0), valB=0x100 -> valE=0xF8, cnd=0, cc unchanged. popq with valB=0xF8 -> valE=0x100.
- Backpressure: out_ready=0 after one accept -> in_ready=0. A second subq held on the inputs for 3 cycles leaves valE and cc unchanged. Raising out_ready accepts it on that same edge.
- Halt (0,0) accepted -> out_valid=1, halted=1, in_ready=0 indefinitely. Asserting rst mid-cycle clears all outputs immediately and restores cc={1,0,0}.
- Invalid icode 0xC -> err=1, halted=1, valE=0, cc unchanged.
